// File: rtl/echo_range_bcd.sv
// echo_range_bcd: measures echo pulse width in cm and publishes four BCD digits.
// Ports: sys_clk50m, sys_rst (async low), echo in; dig0..dig3, over_range, done, busy out.
module echo_range_bcd #(
  parameter int CLK_PER_CM = 2900,
  parameter int MAX_CM     = 9999
) (
  input  logic       sys_clk50m,
  input  logic       sys_rst,
  input  logic       echo,
  output logic [3:0] dig0,
  output logic [3:0] dig1,
  output logic [3:0] dig2,
  output logic [3:0] dig3,
  output logic       over_range,
  output logic       done,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MEASURE,
    S_CONVERT,
    S_UPDATE
  } state_t;

  localparam logic [15:0] PRE_TOP = 16'(CLK_PER_CM - 1);
  localparam logic [13:0] CM_MAX  = 14'(MAX_CM);

  state_t      r_state;
  state_t      w_next;

  logic        r_sync1;
  logic        r_echo_s;
  logic        r_echo_d;
  logic        w_rise;
  logic        w_fall;

  logic [15:0] r_pre;
  logic [13:0] r_cm;
  logic        r_sat;
  logic [13:0] r_bin;
  logic [15:0] r_bcd;
  logic [3:0]  r_it;

  logic        w_wrap;
  logic [13:0] w_cm_nxt;
  logic [15:0] w_bcd_adj;
  logic        w_unused;

  logic [15:0] r_dig;
  logic        r_over;
  logic        r_done;
  logic        r_busy;

  always_ff @(posedge sys_clk50m or negedge sys_rst) begin
    if (!sys_rst) begin
      r_sync1  <= 1'b0;
      r_echo_s <= 1'b0;
      r_echo_d <= 1'b0;
    end else begin
      r_sync1  <= echo;
      r_echo_s <= r_sync1;
      r_echo_d <= r_echo_s;
    end
  end

  assign w_rise = r_echo_s & ~r_echo_d;
  assign w_fall = ~r_echo_s & r_echo_d;

  assign w_wrap   = (r_pre == PRE_TOP);
  // Count holds at the cap; the wrap that would overflow sets sat.
  assign w_cm_nxt = (w_wrap && (r_cm != CM_MAX)) ? r_cm + 14'd1 : r_cm;

  always_comb begin
    w_bcd_adj = r_bcd;
    for (int k = 0; k < 4; k++) begin
      if (r_bcd[4*k +: 4] >= 4'd5)
        w_bcd_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
    end
  end

  // Top nibble never reaches 8 for inputs up to 9999.
  assign w_unused = w_bcd_adj[15];

  always_ff @(posedge sys_clk50m or negedge sys_rst) begin
    if (!sys_rst) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:    if (w_rise) w_next = S_MEASURE;
      S_MEASURE: if (w_fall) w_next = S_CONVERT;
      S_CONVERT: if (r_it == 4'd13) w_next = S_UPDATE;
      S_UPDATE:  w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk50m or negedge sys_rst) begin
    if (!sys_rst) begin
      r_pre <= '0;
      r_cm  <= '0;
      r_sat <= 1'b0;
      r_bin <= '0;
      r_bcd <= '0;
      r_it  <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_rise) begin
            r_pre <= '0;
            r_cm  <= '0;
            r_sat <= 1'b0;
          end
        end
        S_MEASURE: begin
          r_pre <= w_wrap ? 16'd0 : r_pre + 16'd1;
          r_cm  <= w_cm_nxt;
          if (w_wrap && (r_cm == CM_MAX))
            r_sat <= 1'b1;
          if (w_fall) begin
            r_bin <= w_cm_nxt;
            r_bcd <= '0;
            r_it  <= '0;
          end
        end
        S_CONVERT: begin
          r_bcd <= {w_bcd_adj[14:0], r_bin[13]};
          r_bin <= {r_bin[12:0], 1'b0};
          r_it  <= r_it + 4'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge sys_clk50m or negedge sys_rst) begin
    if (!sys_rst) begin
      r_dig  <= '0;
      r_over <= 1'b0;
      r_done <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      r_done <= (r_state == S_UPDATE);
      r_busy <= (w_next != S_IDLE);
      if (r_state == S_UPDATE) begin
        r_dig  <= r_bcd;
        r_over <= r_sat;
      end
    end
  end

  assign dig0       = r_dig[3:0];
  assign dig1       = r_dig[7:4];
  assign dig2       = r_dig[11:8];
  assign dig3       = r_dig[15:12];
  assign over_range = r_over;
  assign done       = r_done;
  assign busy       = r_busy;

endmodule

// File: tb/tb_echo_range_bcd.sv
// tb_echo_range_bcd: directed bench for echo_range_bcd.
// Two instances: A (10 clk/cm, cap 9999) and B (10 clk/cm, cap 50).
module tb_echo_range_bcd;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       echo_a = 1'b0;
  logic       echo_b = 1'b0;

  logic [3:0] a_d0, a_d1, a_d2, a_d3;
  logic       a_ovr, a_done, a_busy;
  logic [3:0] b_d0, b_d1, b_d2, b_d3;
  logic       b_ovr, b_done, b_busy;

  int checks = 0;
  int failures = 0;
  int done_cnt_a = 0;

  always #5 clk = ~clk;

  echo_range_bcd #(.CLK_PER_CM(10), .MAX_CM(9999)) u_a (
    .sys_clk50m (clk),
    .sys_rst    (rst_n),
    .echo       (echo_a),
    .dig0       (a_d0),
    .dig1       (a_d1),
    .dig2       (a_d2),
    .dig3       (a_d3),
    .over_range (a_ovr),
    .done       (a_done),
    .busy       (a_busy)
  );

  echo_range_bcd #(.CLK_PER_CM(10), .MAX_CM(50)) u_b (
    .sys_clk50m (clk),
    .sys_rst    (rst_n),
    .echo       (echo_b),
    .dig0       (b_d0),
    .dig1       (b_d1),
    .dig2       (b_d2),
    .dig3       (b_d3),
    .over_range (b_ovr),
    .done       (b_done),
    .busy       (b_busy)
  );

  always @(posedge clk) if (a_done) done_cnt_a++;

  function automatic logic [15:0] digs(input logic sel);
    return sel ? {b_d3, b_d2, b_d1, b_d0} : {a_d3, a_d2, a_d1, a_d0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_echo(input logic sel, input logic v);
    if (sel) echo_b = v;
    else     echo_a = v;
  endtask

  // Echo high for n cycles, then expect a publish 18 negedges after
  // the pin falls (2 sync + 1 fall + 14 convert + 1 update).
  task automatic meas(input string tag, input logic sel, input int n,
                      input logic [15:0] exp_dig, input logic exp_ovr);
    int lat;
    set_echo(sel, 1'b1);
    repeat (n) @(negedge clk);
    chk({tag, "_busy_meas"}, sel ? b_busy : a_busy, 1);
    set_echo(sel, 1'b0);
    lat = 0;
    while (!(sel ? b_done : a_done) && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, lat, 18);
    chk({tag, "_dig"}, digs(sel), exp_dig);
    chk({tag, "_ovr"}, sel ? b_ovr : a_ovr, exp_ovr);
    chk({tag, "_busy_done"}, sel ? b_busy : a_busy, 0);
    @(negedge clk);
    chk({tag, "_done_one"}, sel ? b_done : a_done, 0);
    chk({tag, "_dig_hold"}, digs(sel), exp_dig);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int c0;
    repeat (3) @(negedge clk);
    chk("rst_dig_a", digs(1'b0), 0);
    chk("rst_dig_b", digs(1'b1), 0);
    chk("rst_flags_a", {a_ovr, a_done, a_busy}, 0);
    chk("rst_flags_b", {b_ovr, b_done, b_busy}, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_busy", a_busy, 0);

    meas("t1_100cm", 1'b0, 1000, 16'h0100, 1'b0);
    meas("t2_1234", 1'b0, 10 * 1234 + 9, 16'h1234, 1'b0);
    meas("t3_zero", 1'b0, 9, 16'h0000, 1'b0);
    meas("t3_one", 1'b0, 10, 16'h0001, 1'b0);

    meas("t4_sat", 1'b1, 600, 16'h0050, 1'b1);
    meas("t4_cap", 1'b1, 500, 16'h0050, 1'b0);
    meas("t4_12", 1'b1, 123, 16'h0012, 1'b0);

    c0 = done_cnt_a;
    echo_a = 1'b1;
    repeat (77) @(negedge clk);
    echo_a = 1'b0;
    repeat (5) @(negedge clk);
    echo_a = 1'b1;
    repeat (40) @(negedge clk);
    echo_a = 1'b0;
    repeat (60) @(negedge clk);
    chk("t5_done_count", done_cnt_a - c0, 1);
    chk("t5_dig", digs(1'b0), 16'h0007);
    chk("t5_busy", a_busy, 0);

    meas("t6_42", 1'b0, 420, 16'h0042, 1'b0);
    echo_a = 1'b1;
    repeat (20) @(negedge clk);
    chk("t6_busy_pre", a_busy, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_dig", digs(1'b0), 0);
    chk("t6_rst_flags", {a_ovr, a_done, a_busy}, 0);
    chk("t6_rst_dig_b", digs(1'b1), 0);
    repeat (3) @(negedge clk);
    echo_a = 1'b0;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("t6_idle", a_busy, 0);
    meas("t6_25", 1'b0, 250, 16'h0025, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
